gemma_operand_feeder: RTL and testbench

- Sits directly downstream of the accelerator's AXI4 read-data channel (m_axi_gmem R beats).
- Captures one 16-beat x 128-bit operand tile, either activation or weight, into a local tile buffer.
- Replays the tile into one edge of the 16x16 systolic array as a diagonally skewed wavefront.
- One instance serves the activation (west) edge and one serves the weight (north) edge.

---
 rtl/gemma_acc_pkg.sv | 16 +
 rtl/gemma_tile_buffer.sv | 51 +++++
 rtl/gemma_operand_feeder.sv | 112 +++++++++++
 tb/tb_gemma_operand_feeder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gemma_acc_pkg.sv
// Shared accelerator constants and operand-feeder state encoding.
package gemma_acc_pkg;
  localparam int ELEM_W = 8;
  localparam int N      = 16;
  localparam int DATA_W = N * ELEM_W;
  localparam int BEATS  = N;
  localparam int ROW_W  = $clog2(BEATS);
  localparam int STEPS  = 2 * N - 1;
  localparam int STEP_W = $clog2(STEPS);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1,
    ST_FEED = 2'd2
  } feed_state_e;
endpackage

// File: rtl/gemma_tile_buffer.sv
// Operand tile register file with a diagonal (skewed) read port.
module gemma_tile_buffer
  import gemma_acc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [ROW_W-1:0]    wr_row_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                clr_i,
  input  logic [STEP_W-1:0]   step_i,
  output logic [N-1:0]        lane_valid_o,
  output logic [N*ELEM_W-1:0] lane_data_o
);
  logic [DATA_W-1:0] rows_q [BEATS];
  logic [BEATS-1:0]  row_valid_q;
  logic [BEATS-1:0]  row_valid_d;

  always_comb begin
    row_valid_d = row_valid_q;
    if (clr_i)
      row_valid_d = '0;
    else if (wr_en_i)
      row_valid_d[wr_row_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      row_valid_q <= '0;
    else
      row_valid_q <= row_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i)
      rows_q[wr_row_i] <= wr_data_i;
  end

  // Lane i reads row (t - i); rows never written read as zero.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [STEP_W-1:0] d;
    logic              ok;
    logic [ROW_W-1:0]  r;
    assign d  = step_i - STEP_W'(i);
    assign ok = (step_i >= STEP_W'(i)) && (d < STEP_W'(BEATS));
    assign r  = d[ROW_W-1:0];
    assign lane_valid_o[i] = ok;
    assign lane_data_o[i*ELEM_W +: ELEM_W] =
      (ok && row_valid_q[r]) ? rows_q[r][i*ELEM_W +: ELEM_W] : '0;
  end
endmodule

// File: rtl/gemma_operand_feeder.sv
// Captures one AXI read tile and replays it as a skewed systolic wavefront.
module gemma_operand_feeder
  import gemma_acc_pkg::*;
(
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  input  logic                feed_start,
  input  logic                feed_hold,
  input  logic                err_clr,
  output logic                tile_full,
  output logic                feed_busy,
  output logic                feed_done,
  output logic                out_valid,
  output logic [N-1:0]        out_lane_valid,
  output logic [N*ELEM_W-1:0] out_data,
  output logic                err_len
);
  feed_state_e       state_q, state_d;
  logic [ROW_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              err_q, err_d;
  logic              wr_en, clr;
  logic              at_last, last_step, stepping;
  logic [N-1:0]        lv;
  logic [N*ELEM_W-1:0] ld;

  assign at_last   = beat_cnt_q == ROW_W'(BEATS - 1);
  assign last_step = step_cnt_q == STEP_W'(STEPS - 1);
  assign stepping  = (state_q == ST_FEED) && !feed_hold;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    step_cnt_d = step_cnt_q;
    err_d      = err_clr ? 1'b0 : err_q;
    wr_en      = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          wr_en      = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (in_last || at_last) begin
            state_d    = ST_FULL;
            beat_cnt_d = '0;
            // Burst length must end exactly on the last row.
            if (in_last != at_last)
              err_d = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (feed_start) begin
          state_d    = ST_FEED;
          step_cnt_d = '0;
        end
      end
      ST_FEED: begin
        if (!feed_hold) begin
          if (last_step) begin
            state_d    = ST_FILL;
            step_cnt_d = '0;
            beat_cnt_d = '0;
            clr        = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= ST_FILL;
      beat_cnt_q <= '0;
      step_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      step_cnt_q <= step_cnt_d;
      err_q      <= err_d;
    end
  end

  gemma_tile_buffer u_buf (
    .clk_i        (ap_clk),
    .rst_i        (ap_rst),
    .wr_en_i      (wr_en),
    .wr_row_i     (beat_cnt_q),
    .wr_data_i    (in_data),
    .clr_i        (clr),
    .step_i       (step_cnt_q),
    .lane_valid_o (lv),
    .lane_data_o  (ld)
  );

  assign in_ready       = state_q == ST_FILL;
  assign tile_full      = state_q == ST_FULL;
  assign feed_busy      = state_q == ST_FEED;
  assign out_valid      = stepping;
  assign feed_done      = stepping && last_step;
  assign out_lane_valid = stepping ? lv : '0;
  assign out_data       = stepping ? ld : '0;
  assign err_len        = err_q;
endmodule

// File: tb/tb_gemma_operand_feeder.sv
// Scoreboard bench for gemma_operand_feeder.
module tb_gemma_operand_feeder;
  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         feed_start = 1'b0;
  logic         feed_hold = 1'b0;
  logic         err_clr = 1'b0;
  logic         tile_full, feed_busy, feed_done, out_valid, err_len;
  logic [15:0]  out_lane_valid;
  logic [127:0] out_data;

  typedef struct packed {
    logic [15:0]  lv;
    logic [127:0] data;
    logic         done;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] exp_rows[16];
  bit   [15:0]  exp_rv;
  logic [15:0]  cap_lv[40];
  logic [127:0] cap_data[40];
  logic         cap_done[40];
  int           cap_idx;
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc;

  always #5 ap_clk = ~ap_clk;

  gemma_operand_feeder dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .feed_start(feed_start), .feed_hold(feed_hold),
    .err_clr(err_clr), .tile_full(tile_full),
    .feed_busy(feed_busy), .feed_done(feed_done),
    .out_valid(out_valid), .out_lane_valid(out_lane_valid),
    .out_data(out_data), .err_len(err_len)
  );

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] st();
    return {in_ready, tile_full, feed_busy, err_len};
  endfunction

  always @(negedge ap_clk) begin
    if (!ap_rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_step", 160'({out_lane_valid, out_data}), 160'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("step%0d", cap_idx),
            160'({out_lane_valid, out_data, feed_done}), 160'(e));
        if (cap_idx < 40) begin
          cap_lv[cap_idx]   = out_lane_valid;
          cap_data[cap_idx] = out_data;
          cap_done[cap_idx] = feed_done;
        end
        cap_idx++;
      end
    end
  end

  task automatic push_feed();
    cap_idx = 0;
    for (int t = 0; t < 31; t++) begin
      exp_t e;
      e = '0;
      for (int i = 0; i < 16; i++) begin
        int r;
        r = t - i;
        if (r >= 0 && r < 16) begin
          e.lv[i] = 1'b1;
          if (exp_rv[r]) e.data[i*8 +: 8] = exp_rows[r][i*8 +: 8];
        end
      end
      e.done = (t == 30);
      exp_q.push_back(e);
    end
  endtask

  task automatic load(input int nb, input int last_at,
                      input logic [7:0] mask, input bit gaps);
    exp_rv = '0;
    for (int r = 0; r < nb; r++) begin
      logic [127:0] d;
      for (int j = 0; j < 16; j++) d[j*8 +: 8] = 8'(r * 16 + j) ^ mask;
      in_data     = d;
      in_last     = (r == last_at);
      in_valid    = 1'b1;
      exp_rows[r] = d;
      exp_rv[r]   = 1'b1;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (gaps) begin @(posedge ap_clk); #1; end
    end
  endtask

  task automatic feed(input int hold_at, input int hold_len,
                      input int ign_at, output int cycles);
    int step, held;
    push_feed();
    feed_start = 1'b1;
    @(posedge ap_clk); #1;
    feed_start = 1'b0;
    cycles = 0; step = 0; held = 0;
    while (feed_busy && cycles < 100) begin
      if (step == hold_at && held < hold_len) begin
        feed_hold = 1'b1;
        held++;
        #1;
        chk("hold_zero", 160'({out_valid, feed_done, out_lane_valid, out_data}),
            160'(0));
      end else begin
        feed_hold  = 1'b0;
        feed_start = (step == ign_at);
        step++;
      end
      @(posedge ap_clk); #1;
      feed_start = 1'b0;
      cycles++;
    end
    feed_hold = 1'b0;
    if (cycles >= 100) chk("feed_timeout", 160'(cycles), 160'(0));
  endtask

  initial begin
    exp_rv = '0;
    #23;
    chk("reset_outputs", 160'({in_ready, tile_full, feed_busy, feed_done,
        out_valid, err_len, out_lane_valid, out_data}), 160'({1'b1, 149'd0}));
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    // feed_start while filling does nothing
    feed_start = 1'b1;
    @(posedge ap_clk); #1;
    feed_start = 1'b0;
    @(posedge ap_clk); #1;
    chk("start_in_fill", 160'(st()), 160'(4'b1000));

    // normal load and feed, with a stray start mid-feed
    load(16, 15, 8'h00, 1'b0);
    chk("normal_full", 160'(st()), 160'(4'b0100));
    feed(-1, 0, 3, cyc);
    chk("normal_len", 160'(cyc), 160'(31));
    chk("ready_after", 160'(st()), 160'(4'b1000));
    chk("t0", 160'({cap_lv[0], cap_data[0][7:0]}), 160'({16'h0001, 8'h00}));
    chk("t1", 160'({cap_data[1][15:8], cap_data[1][7:0]}), 160'(16'h0110));
    chk("t15", 160'({cap_lv[15], cap_data[15][127:120], cap_data[15][7:0]}),
        160'({16'hFFFF, 8'h0F, 8'hF0}));
    chk("t30", 160'({cap_lv[30], cap_data[30], cap_done[30]}),
        160'({16'h8000, 8'hFF, 120'd0, 1'b1}));

    // early in_last on beat 7
    load(8, 7, 8'h00, 1'b0);
    chk("early_err", 160'(st()), 160'(4'b0101));
    feed(-1, 0, -1, cyc);
    chk("early_len", 160'(cyc), 160'(31));
    chk("early_row8", 160'({cap_lv[8][0], cap_data[8][7:0]}), 160'({1'b1, 8'h00}));
    chk("early_row7", 160'(cap_data[7][7:0]), 160'(8'h70));
    err_clr = 1'b1;
    @(posedge ap_clk); #1;
    err_clr = 1'b0;
    chk("err_clr", 160'(st()), 160'(4'b1000));

    // missing in_last, with err_clr held: the new error wins
    err_clr = 1'b1;
    load(16, -1, 8'h3C, 1'b0);
    err_clr = 1'b0;
    chk("missing_err", 160'(st()), 160'(4'b0101));
    in_valid = 1'b1;
    in_data  = {16{8'hEE}};
    repeat (2) begin
      @(posedge ap_clk); #1;
      chk("full_no_ready", 160'({in_ready, tile_full}), 160'(2'b01));
    end
    in_valid = 1'b0;
    feed(-1, 0, -1, cyc);
    chk("missing_len", 160'(cyc), 160'(31));

    // gapped load, then hold 3 cycles at t=5
    load(16, 15, 8'hA5, 1'b1);
    chk("sticky_err", 160'(st()), 160'(4'b0101));
    feed(5, 3, -1, cyc);
    chk("hold_len", 160'(cyc), 160'(34));

    // asynchronous reset in the middle of a feed
    load(16, 15, 8'h5A, 1'b0);
    push_feed();
    feed_start = 1'b1;
    @(posedge ap_clk); #1;
    feed_start = 1'b0;
    repeat (10) @(posedge ap_clk);
    #3;
    ap_rst = 1'b1;
    #1;
    chk("async_rst", 160'({in_ready, tile_full, feed_busy, feed_done, out_valid,
        err_len, out_lane_valid, out_data}), 160'({1'b1, 149'd0}));
    chk("rst_consumed", 160'(exp_q.size()), 160'(21));
    exp_q.delete();
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    chk("post_rst", 160'(st()), 160'(4'b1000));

    load(16, 15, 8'hC3, 1'b0);
    feed(-1, 0, -1, cyc);
    chk("recover_len", 160'(cyc), 160'(31));
    chk("queue_empty", 160'(exp_q.size()), 160'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
